int2ieee: RTL and testbench



---
 rtl/int2ieee.sv | 102 ++++++++++
 tb/tb_int2ieee.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/int2ieee.sv
// Int32 to IEEE-754 single (round to nearest even), normalising one bit per clock.
// Latency 1 edge for zero, lz+2 otherwise; in_ready only in IDLE, result held in DONE until out_ready.
module int2ieee (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] mag_q, mag_d;
  logic [7:0]  exp_q, exp_d;
  logic        sign_q, sign_d;
  logic [31:0] out_data_q, out_data_d;

  logic [22:0] man_trunc;
  logic [22:0] man_rnd;
  logic        guard;
  logic        sticky;
  logic        round_up;
  logic        man_carry;
  logic [7:0]  exp_rnd;
  logic [31:0] in_mag;

  assign in_mag = in_data[31] ? (~in_data + 32'd1) : in_data;

  // A carry out of the mantissa only happens when it was all ones, leaving it zero.
  assign man_trunc              = mag_q[30:8];
  assign guard                  = mag_q[7];
  assign sticky                 = |mag_q[6:0];
  assign round_up               = guard & (sticky | man_trunc[0]);
  assign {man_carry, man_rnd}   = {1'b0, man_trunc} + {23'd0, round_up};
  assign exp_rnd                = exp_q + {7'd0, man_carry};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      mag_q      <= 32'd0;
      exp_q      <= 8'd0;
      sign_q     <= 1'b0;
      out_data_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      mag_q      <= mag_d;
      exp_q      <= exp_d;
      sign_q     <= sign_d;
      out_data_q <= out_data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    mag_d      = mag_q;
    exp_d      = exp_q;
    sign_d     = sign_q;
    out_data_d = out_data_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d = in_data[31];
          mag_d  = in_mag;
          exp_d  = 8'd158;
          if (in_data == 32'd0) begin
            out_data_d = 32'd0;
            state_d    = DONE;
          end else begin
            state_d = NORM;
          end
        end
      end
      NORM: begin
        if (!mag_q[31]) begin
          mag_d = {mag_q[30:0], 1'b0};
          exp_d = exp_q - 8'd1;
        end else begin
          exp_d      = exp_rnd;
          out_data_d = {sign_q, exp_rnd, man_rnd};
          state_d    = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_int2ieee.sv
// Directed and random checks of int2ieee: results, latency, backpressure and reset abort.
module tb_int2ieee;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;

  int n_chk;
  int n_pass;

  int2ieee dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, want);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Independent reference: locate the MSB, then round the dropped bits by comparing against half an ulp.
  function automatic logic [31:0] ref_cvt(input logic [31:0] v);
    logic        s;
    logic [31:0] m;
    logic [63:0] q, rem, half;
    int          p, sh;
    s = v[31];
    m = s ? (~v + 32'd1) : v;
    if (m == 32'd0) return 32'd0;
    p = 31;
    while (!m[p]) p--;
    if (p <= 23) begin
      q = {32'd0, m} << (23 - p);
    end else begin
      sh   = p - 23;
      q    = {32'd0, m} >> sh;
      rem  = {32'd0, m} & ((64'd1 << sh) - 64'd1);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q = q + 64'd1;
      if (q == (64'd1 << 24)) begin
        q = q >> 1;
        p++;
      end
    end
    return {s, 8'(p + 127), q[22:0]};
  endfunction

  // One full transaction; lat counts edges from the accept edge to out_valid visible.
  task automatic xfer(input logic [31:0] val, input bit stall,
                      output logic [31:0] res, output int lat);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_data  = val;
    n = 0;
    do begin
      tick();
      n++;
      in_valid = 1'b0;
      in_data  = $urandom;
      if (stall) out_ready = ($urandom_range(0, 3) != 0);
    end while (!out_valid && n < 40);
    lat = n;
    res = out_data;
    if (!out_valid) chk("out_valid_timeout", {31'd0, out_valid}, 32'd1);
    n = 0;
    while (!out_ready && n < 50) begin
      tick();
      n++;
      if (out_data !== res) chk("stall_stable", out_data, res);
      out_ready = ($urandom_range(0, 1) != 0);
    end
    out_ready = 1'b1;
    tick();
  endtask

  logic [31:0] res, v;
  int          lat;

  initial begin
    n_chk     = 0;
    n_pass    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 32'd0;
    out_ready = 1'b1;
    repeat (3) tick();
    chk("rst_out_data", out_data, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data2", out_data, 32'd0);

    xfer(32'd1, 1'b0, res, lat);
    chk("one", res, 32'h3F800000);
    chk("one_lat", 32'(lat), 32'd33);
    xfer(32'hFFFFFFFF, 1'b0, res, lat);
    chk("minus_one", res, 32'hBF800000);
    xfer(32'd0, 1'b0, res, lat);
    chk("zero", res, 32'h00000000);
    chk("zero_lat", 32'(lat), 32'd1);
    xfer(32'h80000000, 1'b0, res, lat);
    chk("int_min", res, 32'hCF000000);
    chk("int_min_lat", 32'(lat), 32'd2);
    xfer(32'h7FFFFFFF, 1'b0, res, lat);
    chk("int_max", res, 32'h4F000000);
    xfer(32'd16777217, 1'b0, res, lat);
    chk("tie_even_down", res, 32'h4B800000);
    xfer(32'd16777219, 1'b0, res, lat);
    chk("tie_even_up", res, 32'h4B800002);
    xfer(32'd16777221, 1'b0, res, lat);
    chk("tie_even_hold", res, 32'h4B800002);

    // Backpressure: result held, new input refused until after the handoff edge.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'd1000;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 40 && !out_valid; i++) tick();
    chk("bp_result", out_data, 32'h447A0000);
    in_valid = 1'b1;
    in_data  = 32'd7;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_hold_data", out_data, 32'h447A0000);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    tick();
    chk("handoff_in_ready", {31'd0, in_ready}, 32'd1);
    chk("handoff_out_valid", {31'd0, out_valid}, 32'd0);
    xfer(32'd7, 1'b0, res, lat);
    chk("after_bp", res, 32'h40E00000);
    chk("after_bp_lat", 32'(lat), 32'd31);

    // Abort mid-normalisation.
    in_valid = 1'b1;
    in_data  = 32'd1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    chk("norm_in_ready", {31'd0, in_ready}, 32'd0);
    chk("norm_out_valid", {31'd0, out_valid}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_out_data", out_data, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    xfer(32'd5, 1'b0, res, lat);
    chk("post_abort", res, 32'h40A00000);
    chk("post_abort_lat", 32'(lat), 32'd31);

    for (int i = 0; i < 6000; i++) begin
      v = $urandom;
      if ($urandom_range(0, 15) == 0) v = v >> $urandom_range(0, 31);
      xfer(v, 1'b1, res, lat);
      chk($sformatf("rand_%0d_%08h", i, v), res, ref_cvt(v));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
